serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- Serial-in/parallel-out receive stage; sits directly downstream of the calculator's serial transmitter.
- Consumes the Bits-wide, LSB-first beat stream plus its busy/valid flag.
- Rebuilds WIDTH-bit words and presents them on a one-deep valid/ready output buffer to the result/display logic.
- A single Clk domain; serial beats are marked by a one-cycle SampleEn strobe generated from the transmit clock by the existing clock-enable logic.

Parameters:
- WIDTH, 32, word width in bits.
- Bits, 1, serial lane width; must divide WIDTH. Elaboration error otherwise.
- BEATS (localparam), WIDTH/Bits, beats per word.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- SampleEn  input  1  one-Clk strobe; SerialIn/SerialValid are sampled only in cycles where it is high.
- SerialValid  input  1  high while the transmitter is sending data beats (its TxBusy).
- SerialIn  input  Bits  serial data beat, LSB-first.
- DataReady  input  1  consumer accepts DataOut when DataValid&&DataReady.
- DataOut  output  WIDTH  received word.
- DataValid  output  1  DataOut holds an unconsumed word.
- RxBusy  output  1  word reception in progress.
- FrameErr  output  1  one-cycle pulse: stream ended mid-word.
- Overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.

Behaviour:
- Reset (async): all outputs 0, shift register 0, beat counter 0, state IDLE, buffer empty.
- "Beat" means SampleEn=1 && SerialValid=1. In cycles with SampleEn=0, serial inputs are ignored.
- Shift rule: shift_reg <= {SerialIn, shift_reg[WIDTH-1:Bits]}. After BEATS beats, the first beat sits in [Bits-1:0].
- State machine:
  - IDLE: on a beat, shift it in, count<=1, RxBusy<=1, go to SHIFT. If BEATS==1, the word completes immediately.
  - SHIFT: on a beat, shift and count++. When the beat makes count==BEATS, the word is complete: count<=0, RxBusy<=0, go to IDLE.
  - SHIFT with SampleEn=1 && SerialValid=0: FrameErr pulse next cycle, partial word discarded, count<=0, RxBusy<=0, go to IDLE.
- Completion latency: the full word appears on DataOut with DataValid=1 on the Clk edge after the final beat's edge, i.e. one cycle.
- Output buffer:
  - DataValid stays high and DataOut stays stable until DataValid&&DataReady; the buffer empties on that edge.
  - Complete while empty: load, DataValid<=1.
  - Complete while full and accepted the same cycle: load the new word, DataValid stays 1 (no bubble, no Overrun).
  - Complete while full and not accepted: new word dropped, old word kept, Overrun pulses one cycle.
- FrameErr and Overrun are never held longer than one cycle and are independent of each other.
- Reception continues in the shift register while the buffer is full; no back-pressure is applied to the serial side.
- Reset mid-word or with the buffer full: everything cleared asynchronously; the next beat after release starts a new word.

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- With the macro:
  - One extra beat follows the data beats; its bit 0 is even parity (XOR of all WIDTH data bits).
  - State PARITY sits between SHIFT and completion.
  - Extra output port ParityErr (1 bit): one-cycle pulse on mismatch; the word is discarded and not loaded.
  - SerialValid dropping in PARITY raises FrameErr.
- Without the macro: no PARITY state, no ParityErr port; the word completes after BEATS beats.

Decomposition:
- Package serial_pkg:
  - rx_state_t enum: IDLE, SHIFT, PARITY.
  - SERIAL_WORD_W=32 default.
  - beats_f(width, bits) function, shared with the transmitter.
- One natural sub-module: serial_rx_buffer, the one-deep valid/ready holding register with overrun detection. The FSM and shifter stay in serial_receiver.

Test Plan:
- Bits=1, stream 32'hA5A5_0F0F LSB-first, 32 beats, DataReady=1 -> DataOut=32'hA5A50F0F, DataValid high one cycle after the 32nd beat; RxBusy high from beat 1 to beat 32.
- Bits=4, 8 beats of 32'h1234_5678 with SampleEn every 3rd cycle -> DataOut=32'h12345678; idle cycles between strobes change nothing.
- Bits=1, SerialValid drops with SampleEn=1 after 10 beats -> FrameErr one-cycle pulse, DataValid stays 0; next full word 32'h0000_0001 is received correctly.
- DataReady=0, two words 32'h11111111 then 32'h22222222 -> Overrun pulse on the second completion, DataOut stays 32'h11111111. Repeat with DataReady=1 in the completion cycle -> DataOut=32'h22222222, no Overrun.
- Reset asserted after 16 of 32 beats with a word buffered -> all outputs 0 immediately; next 32 beats of 32'hDEADBEEF -> DataOut=32'hDEADBEEF.
- SERIAL_RX_PARITY_EN, word 32'h0000_0003 with parity beat 1 -> ParityErr pulse, no DataValid; parity beat 0 -> DataOut=32'h00000003.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial link (receiver and transmitter).
package serial_pkg;

    localparam int SERIAL_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    function automatic int beats_f(input int width, input int bits);
        return width / bits;
    endfunction

endpackage

// File: rtl/serial_rx_buffer.sv
// rtl/serial_rx_buffer.sv - one-deep valid/ready holding register with overrun detection.
module serial_rx_buffer
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A word accepted on the same edge frees the slot, so no bubble.
                if (!r_valid || i_ready) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - LSB-first serial-to-parallel receive stage with one-deep output buffer.
// Optional trailing even-parity beat enabled by SERIAL_RX_PARITY_EN.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_W,
    parameter int Bits  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SampleEn,
    input  logic             SerialValid,
    input  logic [Bits-1:0]  SerialIn,
    input  logic             DataReady,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    output logic             RxBusy,
    output logic             FrameErr,
`ifdef SERIAL_RX_PARITY_EN
    output logic             ParityErr,
`endif
    output logic             Overrun
);

    localparam int            BEATS = beats_f(WIDTH, Bits);
    localparam int            CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

    if (WIDTH % Bits != 0) begin : g_bad_bits
        $error("serial_receiver: Bits must divide WIDTH");
    end

    rx_state_t        r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic             r_busy;
    logic             r_frame_err;
    logic             r_done;
`ifdef SERIAL_RX_PARITY_EN
    logic             r_parity_err;
`endif

    logic             w_beat;
    logic             w_drop;
    logic [WIDTH-1:0] w_shift_next;

    assign w_beat = SampleEn && SerialValid;
    assign w_drop = SampleEn && !SerialValid;

    if (BEATS == 1) begin : g_one_beat
        assign w_shift_next = SerialIn;
    end else begin : g_multi_beat
        assign w_shift_next = {SerialIn, r_shift[WIDTH-1:Bits]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE, SHIFT: begin
                    // r_count is always 0 in IDLE, so one path covers both states.
                    if (w_beat) begin
                        r_shift <= w_shift_next;
                        if (r_count == LAST) begin
                            r_count <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            r_state <= PARITY;
                            r_busy  <= 1'b1;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_count <= r_count + CW'(1);
                            r_busy  <= 1'b1;
                            r_state <= SHIFT;
                        end
                    end else if (w_drop && r_state == SHIFT) begin
                        r_frame_err <= 1'b1;
                        r_count     <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (w_beat) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (SerialIn[0] == ^r_shift) r_done <= 1'b1;
                        else                         r_parity_err <= 1'b1;
                    end else if (w_drop) begin
                        r_frame_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RxBusy   = r_busy;
    assign FrameErr = r_frame_err;
`ifdef SERIAL_RX_PARITY_EN
    assign ParityErr = r_parity_err;
`endif

    serial_rx_buffer #(
        .WIDTH (WIDTH)
    ) u_buffer (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_load    (r_done),
        .i_data    (r_shift),
        .i_ready   (DataReady),
        .o_data    (DataOut),
        .o_valid   (DataValid),
        .o_overrun (Overrun)
    );

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed self-checking bench for serial_receiver (Bits=1 and Bits=4).
module tb_serial_receiver;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        se1 = 1'b0, sv1 = 1'b0, si1 = 1'b0, rdy1 = 1'b0;
    logic [31:0] dout1;
    logic        dval1, busy1, ferr1, ovr1;

    logic        se4 = 1'b0, sv4 = 1'b0, rdy4 = 1'b0;
    logic [3:0]  si4 = 4'h0;
    logic [31:0] dout4;
    logic        dval4, busy4, ferr4, ovr4;

`ifdef SERIAL_RX_PARITY_EN
    logic        perr1, perr4;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    serial_receiver #(.WIDTH(32), .Bits(1)) u_dut1 (
        .Clk         (Clk),
        .Reset       (Reset),
        .SampleEn    (se1),
        .SerialValid (sv1),
        .SerialIn    (si1),
        .DataReady   (rdy1),
        .DataOut     (dout1),
        .DataValid   (dval1),
        .RxBusy      (busy1),
        .FrameErr    (ferr1),
`ifdef SERIAL_RX_PARITY_EN
        .ParityErr   (perr1),
`endif
        .Overrun     (ovr1)
    );

    serial_receiver #(.WIDTH(32), .Bits(4)) u_dut4 (
        .Clk         (Clk),
        .Reset       (Reset),
        .SampleEn    (se4),
        .SerialValid (sv4),
        .SerialIn    (si4),
        .DataReady   (rdy4),
        .DataOut     (dout4),
        .DataValid   (dval4),
        .RxBusy      (busy4),
        .FrameErr    (ferr4),
`ifdef SERIAL_RX_PARITY_EN
        .ParityErr   (perr4),
`endif
        .Overrun     (ovr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic beat1(input logic b);
        se1 = 1'b1;
        sv1 = 1'b1;
        si1 = b;
        tick();
        se1 = 1'b0;
        sv1 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] w);
        for (int i = 0; i < 32; i++) beat1(w[i]);
`ifdef SERIAL_RX_PARITY_EN
        beat1(^w);
`endif
    endtask

    logic [31:0] w;

    initial begin
        tick();
        tick();
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dval1", dval1, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_ferr1", ferr1, 1'b0);
        chk("rst_ovr1",  ovr1,  1'b0);
        chk("rst_dval4", dval4, 1'b0);
        Reset = 1'b0;
        tick();

        // Bits=1 basic word, latency and busy window
        rdy1 = 1'b1;
        w = 32'hA5A5_0F0F;
        for (int i = 0; i < 32; i++) begin
            beat1(w[i]);
            if (i == 0)  chk("busy_beat1",  busy1, 1'b1);
            if (i == 30) chk("busy_beat31", busy1, 1'b1);
        end
`ifdef SERIAL_RX_PARITY_EN
        beat1(^w);
`endif
        chk("busy_after_last",  busy1, 1'b0);
        chk("dval_before_lat",  dval1, 1'b0);
        tick();
        chk("word1_valid", dval1, 1'b1);
        chk("word1_data",  dout1, 32'hA5A5_0F0F);
        tick();
        chk("word1_consumed", dval1, 1'b0);

        // Bits=4, strobe every third cycle with junk in the gaps
        rdy4 = 1'b1;
        w = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            se4 = 1'b1;
            sv4 = 1'b1;
            si4 = w[4*i +: 4];
            tick();
            se4 = 1'b0;
            sv4 = 1'b0;
            si4 = 4'hF;
            if (i < 7) begin
                tick();
                tick();
            end
            if (i == 3) begin
                chk("b4_mid_busy", busy4, 1'b1);
                chk("b4_mid_ferr", ferr4, 1'b0);
                chk("b4_mid_dval", dval4, 1'b0);
            end
        end
`ifdef SERIAL_RX_PARITY_EN
        tick();
        tick();
        se4 = 1'b1;
        sv4 = 1'b1;
        si4 = {3'b000, ^w};
        tick();
        se4 = 1'b0;
        sv4 = 1'b0;
`endif
        chk("b4_dval_before_lat", dval4, 1'b0);
        tick();
        chk("b4_valid", dval4, 1'b1);
        chk("b4_data",  dout4, 32'h1234_5678);

        // Frame error after 10 beats, then a clean word
        for (int i = 0; i < 10; i++) beat1(1'b1);
        se1 = 1'b1;
        sv1 = 1'b0;
        tick();
        se1 = 1'b0;
        chk("ferr_pulse", ferr1, 1'b1);
        chk("ferr_busy",  busy1, 1'b0);
        tick();
        chk("ferr_one_cycle", ferr1, 1'b0);
        chk("ferr_no_dval",   dval1, 1'b0);
        send1(32'h0000_0001);
        tick();
        chk("after_ferr_valid", dval1, 1'b1);
        chk("after_ferr_data",  dout1, 32'h0000_0001);
        tick();

        // Overrun with buffer full, then same-cycle accept
        rdy1 = 1'b0;
        send1(32'h1111_1111);
        tick();
        chk("ovr_first_data", dout1, 32'h1111_1111);
        send1(32'h2222_2222);
        tick();
        chk("ovr_pulse",     ovr1,  1'b1);
        chk("ovr_keep_data", dout1, 32'h1111_1111);
        chk("ovr_keep_dval", dval1, 1'b1);
        tick();
        chk("ovr_one_cycle", ovr1, 1'b0);
        send1(32'h2222_2222);
        rdy1 = 1'b1;
        tick();
        chk("nobubble_data", dout1, 32'h2222_2222);
        chk("nobubble_dval", dval1, 1'b1);
        chk("nobubble_ovr",  ovr1,  1'b0);
        tick();
        chk("nobubble_consumed", dval1, 1'b0);

        // Reset mid-word with a word buffered
        rdy1 = 1'b0;
        send1(32'h1111_1111);
        tick();
        w = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) beat1(w[i]);
        chk("pre_rst_busy", busy1, 1'b1);
        Reset = 1'b1;
        #1;
        chk("async_rst_dval", dval1, 1'b0);
        chk("async_rst_dout", dout1, 32'h0);
        chk("async_rst_busy", busy1, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        rdy1 = 1'b1;
        send1(32'hDEAD_BEEF);
        tick();
        chk("post_rst_data", dout1, 32'hDEAD_BEEF);
        chk("post_rst_dval", dval1, 1'b1);
        tick();

`ifdef SERIAL_RX_PARITY_EN
        w = 32'h0000_0003;
        for (int i = 0; i < 32; i++) beat1(w[i]);
        beat1(1'b1);
        chk("par_err_pulse", perr1, 1'b1);
        tick();
        chk("par_err_once",  perr1, 1'b0);
        chk("par_err_nodv",  dval1, 1'b0);
        send1(32'h0000_0003);
        tick();
        chk("par_ok_data", dout1, 32'h0000_0003);
        chk("par_ok_dval", dval1, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
